bit_reorder_pipe: RTL and testbench
===================================

# bit_reorder_pipe

Parametrised, two-stage pipelined bit-reordering engine with a valid/ready handshake on both sides. Each accepted word is bit-reversed, byte-reversed, group-reversed, or passed through, as selected per word. A saturating transfer counter counts completed output transfers. It sits between a producer and a consumer that both use valid/ready streaming, and it replaces the earlier single-width, combinational `reverse`-function usage.

## Interface
- WIDTH, 32, data word width; must be ≥ 2.
- GROUP, 4, group size in bits for GROUPREV mode; must divide WIDTH.
- CNT_W, 16, width of the transfer counter.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  input word.
- in_mode  in  2  per-word operation: 0 PASS, 1 BITREV, 2 BYTEREV, 3 GROUPREV.
- out_valid  out  1  out_data/out_mode hold a result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  reordered word.
- out_mode  out  2  mode the word was processed with.
- clr_count  in  1  synchronous clear of xfer_count.
- xfer_count  out  CNT_W  saturating count of output handshakes.

## Operation
- Input handshake: in_valid && in_ready on a clk edge. Output handshake: out_valid && out_ready.
- PASS: out = in.
- BITREV: out[WIDTH-1-k] = in[k] for all k.
- BYTEREV: byte i moves to byte position WIDTH/8-1-i.
  - Applies only when WIDTH % 8 == 0.
  - Otherwise the word is passed unchanged and out_mode reports 0.
- GROUPREV: GROUP-bit group i moves to group position WIDTH/GROUP-1-i. Bit order within each group is preserved.
- Stage 1 (S1) registers in_data/in_mode on an input handshake.
- The reorder logic is combinational from S1. Stage 2 (S2) registers the result and drives out_data/out_mode/out_valid.
- Each stage is a valid-bit plus payload register:
  - S2 loads when S1 is valid and (S2 empty or out_ready).
  - S1 loads when in_valid and (S1 empty or S1 advancing this cycle).
- in_ready = !S1_valid || S1 advancing this cycle.
  - This is a combinational path from out_ready to in_ready, permitted by design.
- While out_valid && !out_ready, out_data and out_mode are held stable.
- Words are never dropped, duplicated or reordered.
- xfer_count increments on each output handshake and saturates at 2^CNT_W−1.
- clr_count has priority: if it coincides with a handshake, the result is 0.
- Reset (asynchronous, at any time):
  - S1_valid, S2_valid, out_valid = 0; all payload registers = 0; out_mode = 0; xfer_count = 0.
  - In-flight words are discarded.
  - in_ready reads 1 as soon as reset deasserts.

## Timing
- Latency: a word accepted at edge N is presented with out_valid = 1 after edge N+1 and is consumable at edge N+2.
- Throughput: one word per cycle while out_ready = 1.
- Capacity: 2 words. With out_ready held low, in_ready falls after the second accepted word.
- Simultaneous handshakes: a word leaving S2 and a word entering S1 in the same cycle are both legal, with no bubble.
- Counter update is visible the cycle after the handshake edge.

## Structure
- Package bit_reorder_pkg holds:
  - mode enum/constants: MODE_PASS = 0, MODE_BITREV = 1, MODE_BYTEREV = 2, MODE_GROUPREV = 3.
  - automatic functions reverse_bits, reverse_bytes and reverse_groups, parametrised by width and group.
- Sub-module bit_reorder_stage: one valid/ready register slice, parametrised by payload width, instantiated twice (S1, S2).
- Top level holds the reorder mux and the saturating counter.

## Test plan
- WIDTH=32, GROUP=4, with out_ready = 1 throughout:
  - mode 1, 0x0000_0001 -> 0x8000_0000.
  - mode 2, 0x1122_3344 -> 0x4433_2211.
  - mode 3, 0x1234_5678 -> 0x8765_4321.
  - mode 0, 0xDEAD_BEEF -> 0xDEAD_BEEF.
  - Each result has out_valid exactly 2 edges after acceptance.
- Back-to-back stream of 0x01..0x08 in mode 1 with out_ready = 1 -> one output per cycle, no bubbles, xfer_count = 8.
- Backpressure: stream 5 words and hold out_ready low for 4 cycles -> in_ready = 0 after 2 accepts, out_data held constant, then all 5 words emerge in order.
- CNT_W=4: 17 handshakes -> xfer_count = 15. Then clr_count asserted in the same cycle as a handshake -> xfer_count = 0.
- Reset asserted mid-edge with 2 words in flight -> out_valid = 0 immediately with no clock, xfer_count = 0. After release, a new word emerges after 2 edges.
- WIDTH=12, mode 2, 0xABC -> out_data = 0xABC, out_mode = 0.

Source files
------------

// File: rtl/bit_reorder_pkg.sv
// bit_reorder_pkg
//   Shared definitions for the bit_reorder_pipe slice: the per-word mode
//   encoding and the reordering helper functions.
//   The helpers work on a MAX_W-bit container; callers zero-extend their
//   WIDTH-bit word in and truncate the result back to WIDTH bits.
package bit_reorder_pkg;

    typedef enum logic [1:0] {
        MODE_PASS     = 2'd0,
        MODE_BITREV   = 2'd1,
        MODE_BYTEREV  = 2'd2,
        MODE_GROUPREV = 2'd3
    } mode_e;

    // Widest word the helpers can handle.
    localparam int unsigned MAX_W = 256;
    localparam int unsigned IDX_W = $clog2(MAX_W);

    // out[width-1-k] = in[k]
    function automatic logic [MAX_W-1:0] reverse_bits(
        input logic [MAX_W-1:0] d,
        input int unsigned      width
    );
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < MAX_W; k++) begin
            if (k < width) begin
                r[IDX_W'(width - 1 - k)] = d[IDX_W'(k)];
            end
        end
        return r;
    endfunction

    // Byte i moves to byte width/8-1-i; words that are not a whole number
    // of bytes come back unchanged.
    function automatic logic [MAX_W-1:0] reverse_bytes(
        input logic [MAX_W-1:0] d,
        input int unsigned      width
    );
        logic [MAX_W-1:0] r;
        int unsigned      nbytes;
        int unsigned      dst;
        if (width % 8 != 0) begin
            return d;
        end
        r      = '0;
        nbytes = width / 8;
        for (int unsigned k = 0; k < MAX_W; k++) begin
            if (k < width) begin
                dst = (nbytes - 1 - k / 8) * 8 + k % 8;
                r[IDX_W'(dst)] = d[IDX_W'(k)];
            end
        end
        return r;
    endfunction

    // Group i (group bits wide) moves to group width/group-1-i; bit order
    // inside a group is kept.
    function automatic logic [MAX_W-1:0] reverse_groups(
        input logic [MAX_W-1:0] d,
        input int unsigned      width,
        input int unsigned      group
    );
        logic [MAX_W-1:0] r;
        int unsigned      ngroups;
        int unsigned      dst;
        r       = '0;
        ngroups = width / group;
        for (int unsigned k = 0; k < MAX_W; k++) begin
            if (k < width) begin
                dst = (ngroups - 1 - k / group) * group + k % group;
                r[IDX_W'(dst)] = d[IDX_W'(k)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_reorder_stage.sv
// bit_reorder_stage
//   One valid/ready register slice: a valid bit plus a W-bit payload.
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     i_valid, o_ready  upstream handshake (o_ready may depend on i_ready)
//     i_data            upstream payload
//     o_valid, i_ready  downstream handshake
//     o_data            registered payload, held while stalled
module bit_reorder_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_load;

    // Accept when empty or when the held word leaves this same cycle.
    assign o_ready = !r_valid || i_ready;
    assign w_load  = i_valid && o_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/bit_reorder_pipe.sv
// bit_reorder_pipe
//   Two-stage pipelined bit-reordering engine. S1 captures the input word
//   and mode, the reorder mux works combinationally from S1, S2 registers
//   the result. A saturating counter tallies output handshakes.
//   Ports:
//     clk, reset                    clock, asynchronous active-high reset
//     in_valid/in_ready             input handshake
//     in_data[WIDTH], in_mode[2]    word and mode (PASS/BITREV/BYTEREV/GROUPREV)
//     out_valid/out_ready           output handshake
//     out_data[WIDTH], out_mode[2]  reordered word and the mode actually applied
//     clr_count                     synchronous clear, wins over a handshake
//     xfer_count[CNT_W]             saturating output-handshake count
module bit_reorder_pipe
    import bit_reorder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_mode,
    input  logic             clr_count,
    output logic [CNT_W-1:0] xfer_count
);

    localparam int unsigned PW      = WIDTH + 2;
    localparam bit          BYTE_OK = (WIDTH % 8 == 0);

    logic             w_s1_valid;
    logic             w_s2_ready;
    logic [PW-1:0]    w_s1_payload;
    logic [WIDTH-1:0] w_s1_data;
    mode_e            w_s1_mode;
    logic [WIDTH-1:0] w_res_data;
    mode_e            w_res_mode;
    logic [PW-1:0]    w_s2_payload;
    logic [CNT_W-1:0] r_count;

    bit_reorder_stage #(.W(PW)) u_s1 (
        .clk     (clk),
        .reset   (reset),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  ({in_mode, in_data}),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_payload)
    );

    assign w_s1_data = w_s1_payload[WIDTH-1:0];
    assign w_s1_mode = mode_e'(w_s1_payload[PW-1:WIDTH]);

    always_comb begin
        w_res_data = w_s1_data;
        w_res_mode = w_s1_mode;
        case (w_s1_mode)
            MODE_PASS: ;
            MODE_BITREV:
                w_res_data = WIDTH'(reverse_bits(MAX_W'(w_s1_data), WIDTH));
            MODE_BYTEREV:
                // Non-byte-multiple widths fall back to pass-through and
                // report mode 0 so the consumer sees what was really done.
                if (BYTE_OK) begin
                    w_res_data = WIDTH'(reverse_bytes(MAX_W'(w_s1_data), WIDTH));
                end else begin
                    w_res_mode = MODE_PASS;
                end
            MODE_GROUPREV:
                w_res_data = WIDTH'(reverse_groups(MAX_W'(w_s1_data), WIDTH, GROUP));
        endcase
    end

    bit_reorder_stage #(.W(PW)) u_s2 (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  ({w_res_mode, w_res_data}),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_s2_payload)
    );

    assign out_data = w_s2_payload[WIDTH-1:0];
    assign out_mode = w_s2_payload[PW-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr_count) begin
            r_count <= '0;
        end else if (out_valid && out_ready && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign xfer_count = r_count;

endmodule

// File: tb/tb_bit_reorder_pipe.sv
module tb_bit_reorder_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic        out_ready;
    logic        clr_count;

    logic        in_ready,  out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_mode;
    logic [15:0] cnt16;

    logic        in_ready4, out_valid4;
    logic [31:0] out_data4;
    logic [1:0]  out_mode4;
    logic [3:0]  cnt4;

    logic        in_ready12, out_valid12;
    logic [11:0] out_data12;
    logic [1:0]  out_mode12;
    logic [15:0] cnt12;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned pops     = 0;
    logic        hs_in, hs_out;
    logic [33:0] q[$];
    int unsigned e16, e4;

    bit_reorder_pipe #(.WIDTH(32), .GROUP(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
        .clr_count(clr_count), .xfer_count(cnt16)
    );

    bit_reorder_pipe #(.WIDTH(32), .GROUP(4), .CNT_W(4)) dut_c4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .out_mode(out_mode4),
        .clr_count(clr_count), .xfer_count(cnt4)
    );

    bit_reorder_pipe #(.WIDTH(12), .GROUP(4), .CNT_W(16)) dut12 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready12),
        .in_data(in_data[11:0]), .in_mode(in_mode), .out_valid(out_valid12),
        .out_ready(out_ready), .out_data(out_data12), .out_mode(out_mode12),
        .clr_count(clr_count), .xfer_count(cnt12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: streaming operators express the reorderings directly.
    function automatic logic [33:0] ref32(input logic [31:0] d, input logic [1:0] m);
        logic [31:0] r;
        case (m)
            2'd0:    r = d;
            2'd1:    r = {<<{d}};
            2'd2:    r = {<<8{d}};
            default: r = {<<4{d}};
        endcase
        return {m, r};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, score outputs, model the
    // counters, then check them just after the edge.
    task automatic tick();
        logic [33:0] e;
        @(negedge clk);
        hs_in  = in_valid && in_ready;
        hs_out = out_valid && out_ready;
        if (hs_out) begin
            check("sb_nonempty", 64'(q.size() != 0), 64'(1));
            if (q.size() != 0) begin
                e = q.pop_front();
                pops++;
                check("sb_data", 64'(out_data), 64'(e[31:0]));
                check("sb_mode", 64'(out_mode), 64'(e[33:32]));
            end
        end
        if (hs_in) q.push_back(ref32(in_data, in_mode));
        @(posedge clk);
        #1;
        if (clr_count) begin
            e16 = 0;
            e4  = 0;
        end else if (hs_out) begin
            if (e16 != 65535) e16++;
            if (e4 != 15) e4++;
        end
        check("cnt16", 64'(cnt16), 64'(e16));
        check("cnt4", 64'(cnt4), 64'(e4));
    endtask

    logic [31:0] dv_in [4] = '{32'h0000_0001, 32'h1122_3344, 32'h1234_5678, 32'hDEAD_BEEF};
    logic [1:0]  dv_md [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] dv_out[4] = '{32'h8000_0000, 32'h4433_2211, 32'h8765_4321, 32'hDEAD_BEEF};
    logic [31:0] w[5];
    logic [1:0]  m[5];
    logic [33:0] exp0;
    logic [11:0] w12_exp[3] = '{12'hABC, 12'h3D5, 12'hCBA};
    logic [1:0]  w12_md [3] = '{2'd2, 2'd1, 2'd3};
    logic [1:0]  w12_om [3] = '{2'd0, 2'd1, 2'd3};
    int unsigned idx, p0;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0;
        out_ready = 1'b1; clr_count = 1'b0; e16 = 0; e4 = 0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_mode", 64'(out_mode), 64'(0));
        check("rst_cnt", 64'(cnt16), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Directed single words, latency 2 edges.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = dv_in[i]; in_mode = dv_md[i];
            tick();
            check("dir_accept", 64'(hs_in), 64'(1));
            in_valid = 1'b0;
            check("dir_lat_n1", 64'(out_valid), 64'(0));
            tick();
            check("dir_lat_n2", 64'(out_valid), 64'(1));
            check("dir_data", 64'(out_data), 64'(dv_out[i]));
            check("dir_mode", 64'(out_mode), 64'(dv_md[i]));
            tick();
            check("dir_drained", 64'(out_valid), 64'(0));
        end

        // Back-to-back stream, no bubbles.
        clr_count = 1'b1; tick(); clr_count = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 32'(i); in_mode = 2'd1;
            tick();
            check("b2b_accept", 64'(hs_in), 64'(1));
            if (i >= 2) check("b2b_valid", 64'(out_valid), 64'(1));
        end
        in_valid = 1'b0;
        tick();
        check("b2b_last_valid", 64'(out_valid), 64'(1));
        check("b2b_last_data", 64'(out_data), 64'(32'h1000_0000));
        tick();
        check("b2b_empty", 64'(out_valid), 64'(0));
        check("b2b_count", 64'(cnt16), 64'(8));

        // Backpressure: 5 words, out_ready low for 4 cycles.
        for (int i = 0; i < 5; i++) begin
            w[i] = $urandom; m[i] = 2'($urandom_range(0, 3));
        end
        exp0 = ref32(w[0], m[0]);
        p0 = pops; idx = 0; out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_data = w[idx]; in_mode = m[idx];
            tick();
            if (hs_in) idx++;
            if (c >= 1) begin
                check("bp_in_ready", 64'(in_ready), 64'(0));
                check("bp_hold_data", 64'(out_data), 64'(exp0[31:0]));
                check("bp_hold_mode", 64'(out_mode), 64'(exp0[33:32]));
            end
        end
        check("bp_accepts", 64'(idx), 64'(2));
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (idx == 5 && q.size() == 0) break;
            in_valid = (idx < 5);
            if (idx < 5) begin in_data = w[idx]; in_mode = m[idx]; end
            tick();
            if (hs_in) idx++;
        end
        in_valid = 1'b0;
        check("bp_all_in", 64'(idx), 64'(5));
        check("bp_all_out", 64'(pops - p0), 64'(5));

        // Random traffic against the scoreboard.
        for (int c = 0; c < 300; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            in_mode   = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (q.size() == 0) break;
            tick();
        end
        check("rnd_drained", 64'(q.size()), 64'(0));

        // Counter saturation and clear priority.
        clr_count = 1'b1; tick(); clr_count = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = $urandom; in_mode = 2'($urandom_range(0, 3));
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (q.size() == 0) break;
            tick();
        end
        check("sat_cnt4", 64'(cnt4), 64'(15));
        check("sat_cnt16", 64'(cnt16), 64'(17));
        in_valid = 1'b1; in_data = 32'h0F0F_00FF; in_mode = 2'd2;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        check("clr_pre_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1; clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("clr_hs_cnt4", 64'(cnt4), 64'(0));
        check("clr_hs_cnt16", 64'(cnt16), 64'(0));

        // Asynchronous reset with two words in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = $urandom; in_mode = 2'd1;
            tick();
        end
        in_valid = 1'b0;
        check("ar_full", 64'(in_ready), 64'(0));
        #2 reset = 1'b1;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'(0));
        check("ar_cnt16", 64'(cnt16), 64'(0));
        check("ar_cnt4", 64'(cnt4), 64'(0));
        check("ar_in_ready", 64'(in_ready), 64'(1));
        check("ar_out_data", 64'(out_data), 64'(0));
        q.delete(); e16 = 0; e4 = 0;
        #2 reset = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h1234_5678; in_mode = 2'd3;
        tick();
        in_valid = 1'b0;
        check("ar_new_n1", 64'(out_valid), 64'(0));
        tick();
        check("ar_new_n2", 64'(out_valid), 64'(1));
        check("ar_new_data", 64'(out_data), 64'(32'h8765_4321));
        tick();

        // 12-bit instance: byte reverse is not applicable there.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'h0000_0ABC; in_mode = w12_md[i];
            tick();
            in_valid = 1'b0;
            tick();
            check("w12_valid", 64'(out_valid12), 64'(1));
            check("w12_data", 64'(out_data12), 64'(w12_exp[i]));
            check("w12_mode", 64'(out_mode12), 64'(w12_om[i]));
            tick();
        end
        check("end_q_empty", 64'(q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
